// File: rtl/buff_sequencer.sv
// Burst sequencer for the toggle-driven buffer controller.
// Opens/closes BLOCK-word bursts, tracks occupancy, re-times read data.
module buff_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SIZE   = 64,
    parameter int BLOCK  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    output logic                       wr_grant,
    output logic                       wr_active,
    output logic                       wr_toggle,
    input  logic                       rd_req,
    output logic                       rd_grant,
    output logic                       rd_toggle,
    input  logic [WIDTH-1:0]           buf_rdata,
    output logic                       m_valid,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_last,
    output logic [$clog2(SIZE):0]      level,
    output logic                       can_wr,
    output logic                       can_rd
);

    localparam int LW = $clog2(SIZE) + 1;
    localparam int CW = $clog2(BLOCK);

    typedef enum logic {W_IDLE, W_BURST} w_state_t;
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    w_state_t        wstate;
    r_state_t        rstate;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   rcnt;
    logic            wr_last;
    logic            rd_last;
    logic            rd_act;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] lpipe;

    // Outputs are forced low while rst is held so the controller sees no enable.
    assign can_wr    = !rst && (level <= LW'(SIZE - BLOCK));
    assign can_rd    = !rst && (level >= LW'(BLOCK));

    assign wr_last   = !rst && (wstate == W_BURST) && (wcnt == CW'(BLOCK - 1));
    assign wr_grant  = !rst && (wstate == W_IDLE) && wr_req && can_wr;
    assign wr_active = wr_grant || (!rst && (wstate == W_BURST));
    assign wr_toggle = wr_grant || wr_last;

    assign rd_last   = !rst && (rstate == R_BURST) && (rcnt == CW'(BLOCK - 1));
    assign rd_grant  = !rst && (rstate == R_IDLE) && rd_req && can_rd;
    assign rd_act    = rd_grant || (!rst && (rstate == R_BURST));
    assign rd_toggle = rd_grant || rd_last;

    assign m_valid   = vpipe[RD_LAT-1];
    assign m_last    = lpipe[RD_LAT-1];
    assign m_data    = m_valid ? buf_rdata : '0;

    // Write burst FSM: grant loads count 1, closing toggle at BLOCK-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (wr_grant) begin
                        wstate <= W_BURST;
                        wcnt   <= CW'(1);
                    end
                end
                W_BURST: begin
                    if (wr_last) begin
                        wstate <= W_IDLE;
                        wcnt   <= '0;
                    end else begin
                        wcnt   <= wcnt + CW'(1);
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read burst FSM, same shape as the write side.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rcnt   <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (rd_grant) begin
                        rstate <= R_BURST;
                        rcnt   <= CW'(1);
                    end
                end
                R_BURST: begin
                    if (rd_last) begin
                        rstate <= R_IDLE;
                        rcnt   <= '0;
                    end else begin
                        rcnt   <= rcnt + CW'(1);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Occupancy: words written minus words read.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            unique case ({wr_active, rd_act})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Occupancy can never exceed the buffer depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (level <= LW'(SIZE));
        end
    end

    // Delay read-enable and last flag to line up with buffer read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= rd_act;
            lpipe[0] <= rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

endmodule
